// File: rtl/shl48_arb.sv
// shl48_arb: two-requester round-robin front end to a single shared 48-bit
// left shifter with an optional normalize (leading-zero) mode and a one-deep
// registered result stage with valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid / reqN_ready  per-requester handshake (ready is combinational)
//   reqN_data                48-bit operand
//   reqN_nshift              explicit shift amount (0..63)
//   reqN_norm                shift by the operand's leading-zero count instead
//   out_valid / out_ready    result handshake
//   out_data                 shifted operand (truncated to 48 bits)
//   out_shamt                shift amount applied
//   out_src                  index of the granted requester
//   out_zero                 out_data is all zeros
module shl48_arb #(
  parameter bit NORM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [47:0] req0_data,
  input  logic [5:0]  req0_nshift,
  input  logic        req0_norm,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [47:0] req1_data,
  input  logic [5:0]  req1_nshift,
  input  logic        req1_norm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [47:0] out_data,
  output logic [5:0]  out_shamt,
  output logic        out_src,
  output logic        out_zero
);

  localparam int unsigned W  = 48;
  localparam int unsigned SW = 6;

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_prio;
  logic [W-1:0]  r_data;
  logic [SW-1:0] r_shamt;
  logic          r_src;
  logic          r_zero;

  logic          w_accept_ok;
  logic          w_grant0;
  logic          w_grant1;
  logic          w_load;
  logic [W-1:0]  w_opnd;
  logic [SW-1:0] w_nshift;
  logic          w_norm;
  logic [SW-1:0] w_lzc;
  logic [SW-1:0] w_shamt;
  logic [W-1:0]  w_s1, w_s2, w_s3, w_s4, w_s5, w_s6;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Arbitration and next state; readies held low during reset
  always_comb begin
    w_state_nxt = r_state;
    w_accept_ok = (r_state == EMPTY) | ((r_state == FULL) & out_ready);
    w_grant0    = 1'b0;
    w_grant1    = 1'b0;
    if (w_accept_ok && !rst) begin
      if (req0_valid && req1_valid) begin
        w_grant0 = ~r_prio;
        w_grant1 = r_prio;
      end else begin
        w_grant0 = req0_valid;
        w_grant1 = req1_valid;
      end
    end
    w_load = w_grant0 | w_grant1;
    case (r_state)
      EMPTY: if (w_load) w_state_nxt = FULL;
      FULL:  if (out_ready && !w_load) w_state_nxt = EMPTY;
      default: w_state_nxt = EMPTY;
    endcase
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // Operand select for the shared shifter
  assign w_opnd   = w_grant1 ? req1_data   : req0_data;
  assign w_nshift = w_grant1 ? req1_nshift : req0_nshift;
  assign w_norm   = NORM_EN & (w_grant1 ? req1_norm : req0_norm);

  // Leading-zero count from bit 47; highest set bit wins, zero operand gives 48
  always_comb begin
    w_lzc = SW'(W);
    for (int unsigned i = 0; i < W; i++) begin
      if (w_opnd[i]) w_lzc = SW'(W - 1 - i);
    end
  end

  assign w_shamt = w_norm ? w_lzc : w_nshift;

  // Six-stage left shifter; amounts >= 48 clear the result naturally
  assign w_s1 = w_shamt[5] ? {w_opnd[15:0], 32'd0} : w_opnd;
  assign w_s2 = w_shamt[4] ? {w_s1[31:0],   16'd0} : w_s1;
  assign w_s3 = w_shamt[3] ? {w_s2[39:0],    8'd0} : w_s2;
  assign w_s4 = w_shamt[2] ? {w_s3[43:0],    4'd0} : w_s3;
  assign w_s5 = w_shamt[1] ? {w_s4[45:0],    2'd0} : w_s4;
  assign w_s6 = w_shamt[0] ? {w_s5[46:0],    1'd0} : w_s5;

  // Result register and round-robin pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prio  <= 1'b0;
      r_data  <= '0;
      r_shamt <= '0;
      r_src   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (w_load) begin
      r_prio  <= ~w_grant1;
      r_data  <= w_s6;
      r_shamt <= w_shamt;
      r_src   <= w_grant1;
      r_zero  <= (w_s6 == '0);
    end
  end

  assign out_valid = (r_state == FULL);
  assign out_data  = r_data;
  assign out_shamt = r_shamt;
  assign out_src   = r_src;
  assign out_zero  = r_zero;

endmodule

// File: tb/tb_shl48_arb.sv
// tb_shl48_arb: directed self-checking bench for shl48_arb.
module tb_shl48_arb;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [47:0] req0_data, req1_data;
  logic [5:0]  req0_nshift, req1_nshift;
  logic        req0_norm, req1_norm;
  logic        out_valid, out_ready;
  logic [47:0] out_data;
  logic [5:0]  out_shamt;
  logic        out_src, out_zero;

  int checks = 0;
  int errors = 0;

  shl48_arb #(.NORM_EN(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
    .req0_nshift(req0_nshift), .req0_norm(req0_norm),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
    .req1_nshift(req1_nshift), .req1_norm(req1_norm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_shamt(out_shamt), .out_src(out_src), .out_zero(out_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [47:0] d,
                           input logic [5:0] s, input logic src, input logic z);
    check({tag, ".valid"}, 64'(out_valid), 64'(v));
    check({tag, ".data"},  64'(out_data),  64'(d));
    check({tag, ".shamt"}, 64'(out_shamt), 64'(s));
    check({tag, ".src"},   64'(out_src),   64'(src));
    check({tag, ".zero"},  64'(out_zero),  64'(z));
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, ".rdy0"}, 64'(req0_ready), 64'(r0));
    check({tag, ".rdy1"}, 64'(req1_ready), 64'(r1));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b1; req0_data = 48'h1; req0_nshift = 6'd0; req0_norm = 1'b0;
    req1_valid = 1'b1; req1_data = 48'h1; req1_nshift = 6'd0; req1_norm = 1'b0;
    out_ready = 1'b1;
    #2;
    // Reset state, readies held low despite valid requests
    check_out("reset", 1'b0, 48'h0, 6'd0, 1'b0, 1'b0);
    check_rdy("reset", 1'b0, 1'b0);
    step();
    step();
    check_out("reset_clk", 1'b0, 48'h0, 6'd0, 1'b0, 1'b0);
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    check_rdy("idle", 1'b0, 1'b0);

    // Explicit shift from req0
    req0_valid = 1'b1; req0_data = 48'h0000_0000_00FF; req0_nshift = 6'd8; req0_norm = 1'b0;
    #1;
    check_rdy("shift", 1'b1, 1'b0);
    step();
    check_out("shift", 1'b1, 48'h0000_0000_FF00, 6'd8, 1'b0, 1'b0);

    // Normalize from req1, accepted while FULL and draining
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 48'h0000_0001_2345; req1_norm = 1'b1; req1_nshift = 6'd3;
    #1;
    check_rdy("norm", 1'b0, 1'b1);
    step();
    check_out("norm", 1'b1, 48'h91A2_8000_0000, 6'd31, 1'b1, 1'b0);

    // Normalize of a zero operand
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_data = 48'h0; req0_norm = 1'b1; req0_nshift = 6'd5;
    step();
    check_out("normzero", 1'b1, 48'h0, 6'd48, 1'b0, 1'b1);

    // Explicit shift past the width
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_data = 48'hFFFF_FFFF_FFFF; req1_norm = 1'b0; req1_nshift = 6'd50;
    step();
    check_out("ovf", 1'b1, 48'h0, 6'd50, 1'b1, 1'b1);

    // Drain with nothing pending
    req1_valid = 1'b0;
    #1;
    check_rdy("drain", 1'b0, 1'b0);
    step();
    check("drain.valid", 64'(out_valid), 64'(1'b0));

    // Reset pulse, then contention alternates 0,1,0,1
    rst = 1'b1;
    #1;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 48'h1; req0_nshift = 6'd1; req0_norm = 1'b0;
    req1_valid = 1'b1; req1_data = 48'h1; req1_nshift = 6'd2; req1_norm = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_rdy($sformatf("cont%0d", i), (i % 2) == 0, (i % 2) == 1);
      step();
      if ((i % 2) == 0) check_out($sformatf("cont%0d", i), 1'b1, 48'h2, 6'd1, 1'b0, 1'b0);
      else              check_out($sformatf("cont%0d", i), 1'b1, 48'h4, 6'd2, 1'b1, 1'b0);
    end

    // Backpressure: hold for 3 cycles, then drain and reload together
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_rdy($sformatf("bp%0d", i), 1'b0, 1'b0);
      step();
      check_out($sformatf("bp%0d", i), 1'b1, 48'h4, 6'd2, 1'b1, 1'b0);
    end
    out_ready = 1'b1;
    #1;
    check_rdy("bprel", 1'b1, 1'b0);
    step();
    check_out("bprel", 1'b1, 48'h2, 6'd1, 1'b0, 1'b0);

    // Async reset while FULL; prio is now 1, reset must return it to 0
    out_ready = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check_out("rstmid", 1'b0, 48'h0, 6'd0, 1'b0, 1'b0);
    check_rdy("rstmid", 1'b0, 1'b0);
    step();
    check("rstmid_hold.valid", 64'(out_valid), 64'(1'b0));
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check_rdy("postrst", 1'b1, 1'b0);
    step();
    check_out("postrst", 1'b1, 48'h2, 6'd1, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
